hash_verifier: RTL and testbench
================================

HASH_VERIFIER -- requirements
Module: hash_verifier

Interface
REQ-001 Parameters: none; algorithm constants fixed by REQ-012..REQ-015.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 payload  in  96  block payload being checked.
REQ-006 nonce  in  32  claimed nonce.
REQ-007 hash_in  in  24  claimed hash.
REQ-008 target  in  8  difficulty bound.
REQ-009 busy  out  1  high while a check is in progress.
REQ-010 done  out  1  one-cycle pulse; result outputs valid from then until next accepted start.
REQ-011 hash_calc  out  24 / hash_match  out  1 / meets_target  out  1 / valido  out  1  recomputed hash, hash_calc==hash_in, target check, hash_match AND meets_target.

Function
REQ-012 Message bytes: W[0]=payload[95:88] … W[11]=payload[7:0], W[12]=nonce[31:24] … W[15]=nonce[7:0].
REQ-013 Expansion for i=16..31: W[i] = W[i-3] | (W[i-9] ^ W[i-14]), 8-bit; generated on the fly from a 16-byte sliding window, no 32-entry array.
REQ-014 State a,b,c initialised 8'h01, 8'h89, 8'hfe on accept.
REQ-015 Round i: i<=16 -> k=8'h99, x=a^b; i>=17 -> k=8'ha1, x=a^c.
REQ-016 Round i update: a<=b^c; b<={c[3:0],4'b0}; c<=(x+k+W[i]) mod 256.
REQ-017 All additions mod 256; no carry between bytes.
REQ-018 Final: hash_calc = {(8'h01+a), (8'h89+b), (8'hfe+c)}, each mod 256.
REQ-019 meets_target = (hash_calc[23:16] < target) AND (hash_calc[15:8] < target), unsigned.
REQ-020 FSM states: IDLE, RONDA, FIN.
REQ-021 IDLE: start=1 at edge T0 latches payload, nonce, hash_in, target, init a/b/c; idx<=0; go RONDA; busy<=1.
REQ-022 RONDA: one round per edge, idx 0..31 on edges T1..T32; after round 31, go FIN.
REQ-023 FIN (edge T33): register hash_calc, hash_match, meets_target, valido; done<=1; busy<=0; go IDLE.
REQ-024 done high for exactly the cycle after T33; latency start-accept to done = 33 clocks.
REQ-025 start while busy ignored; latched operands unaffected by input changes after T0.
REQ-026 start high in the done cycle is accepted (FSM in IDLE); result outputs hold until that check's FIN.
REQ-027 Held start re-triggers a new check each time the FSM returns to IDLE.

Reset
REQ-028 reset=1 forces, asynchronously: state IDLE, idx 0, busy 0, done 0, hash_calc 0, hash_match 0, meets_target 0, valido 0.
REQ-029 reset mid-RONDA or mid-FIN aborts the check; no done pulse for the aborted request.
REQ-030 First start after reset deasserts behaves per REQ-021.

Verification
REQ-031 Latency: start one cycle, payload 96'h397d9f2f40ca9e6c6b1f3324, target 8'h0a -> busy high 33 cycles, single done pulse 33 clocks after accept, busy low in done cycle.
REQ-032 Round trip: feed miner's nonceOut/hashOut for that payload, target 8'h0a -> hash_calc==hash_in, hash_match=1, meets_target=1, valido=1; results match an independent software model of REQ-012..REQ-019.
REQ-033 Mismatch: same request with hash_in = correct hash ^ 24'h000001 -> hash_match=0, valido=0, hash_calc unchanged vs. REQ-032.
REQ-034 Target 8'h00, any payload/nonce -> meets_target=0, valido=0.
REQ-035 Second start 5 cycles after accept, with different operands -> ignored; one done; results from first operands.
REQ-036 reset pulse at cycle 10 of RONDA -> all outputs 0 immediately, no done; next start completes normally in 33 clocks with correct result.

Source files
------------

// File: rtl/hash_verifier.sv
// rtl/hash_verifier.sv - recomputes a 32-round byte hash over payload+nonce and checks it against a claimed hash and target
module hash_verifier (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [95:0] i_payload,
    input  logic [31:0] i_nonce,
    input  logic [23:0] i_hash_in,
    input  logic [7:0]  i_target,
    output logic        o_busy,
    output logic        o_done,
    output logic [23:0] o_hash_calc,
    output logic        o_hash_match,
    output logic        o_meets_target,
    output logic        o_valido
);

    typedef enum logic [1:0] {S_IDLE, S_RONDA, S_FIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0][7:0] r_win;
    logic [4:0]      r_idx;
    logic [7:0]      r_a, r_b, r_c;
    logic [23:0]     r_hash_in;
    logic [7:0]      r_target;
    logic            r_busy, r_done, r_match, r_meets, r_valido;
    logic [23:0]     r_hash_calc;

    logic [7:0]      w_k, w_x, w_new;
    logic [23:0]     w_hash;
    logic            w_meets;

    // r_win[0] is always W[r_idx]; the byte shifted in is W[r_idx+16]
    assign w_k     = (r_idx <= 5'd16) ? 8'h99 : 8'ha1;
    assign w_x     = (r_idx <= 5'd16) ? (r_a ^ r_b) : (r_a ^ r_c);
    assign w_new   = r_win[13] | (r_win[7] ^ r_win[2]);
    assign w_hash  = {8'h01 + r_a, 8'h89 + r_b, 8'hfe + r_c};
    assign w_meets = (w_hash[23:16] < r_target) && (w_hash[15:8] < r_target);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RONDA;
            S_RONDA: if (r_idx == 5'd31) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_win       <= '0;
            r_idx       <= 5'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_c         <= 8'd0;
            r_hash_in   <= 24'd0;
            r_target    <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hash_calc <= 24'd0;
            r_match     <= 1'b0;
            r_meets     <= 1'b0;
            r_valido    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int j = 0; j < 12; j++) r_win[j] <= i_payload[95-8*j -: 8];
                        for (int j = 0; j < 4; j++)  r_win[12+j] <= i_nonce[31-8*j -: 8];
                        r_hash_in <= i_hash_in;
                        r_target  <= i_target;
                        r_a       <= 8'h01;
                        r_b       <= 8'h89;
                        r_c       <= 8'hfe;
                        r_idx     <= 5'd0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RONDA: begin
                    r_a <= r_b ^ r_c;
                    r_b <= {r_c[3:0], 4'b0000};
                    r_c <= w_x + w_k + r_win[0];
                    for (int j = 0; j < 15; j++) r_win[j] <= r_win[j+1];
                    r_win[15] <= w_new;
                    r_idx     <= r_idx + 5'd1;
                end
                S_FIN: begin
                    r_hash_calc <= w_hash;
                    r_match     <= (w_hash == r_hash_in);
                    r_meets     <= w_meets;
                    r_valido    <= (w_hash == r_hash_in) && w_meets;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_hash_calc    = r_hash_calc;
    assign o_hash_match   = r_match;
    assign o_meets_target = r_meets;
    assign o_valido       = r_valido;

endmodule

// File: tb/tb_hash_verifier.sv
// tb/tb_hash_verifier.sv - randomized and directed checks of hash_verifier against a byte-array reference model
module tb_hash_verifier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [95:0] payload = '0;
    logic [31:0] nonce = '0;
    logic [23:0] hash_in = '0;
    logic [7:0]  target = '0;
    logic        busy, done, hash_match, meets_target, valido;
    logic [23:0] hash_calc;

    int n_checks = 0;
    int n_fail = 0;

    hash_verifier dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_payload(payload),
        .i_nonce(nonce), .i_hash_in(hash_in), .i_target(target),
        .o_busy(busy), .o_done(done), .o_hash_calc(hash_calc),
        .o_hash_match(hash_match), .o_meets_target(meets_target), .o_valido(valido)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
        logic [7:0] w[32];
        logic [7:0] a, b, c, x, k, t;
        for (int i = 0; i < 12; i++) w[i] = p[95-8*i -: 8];
        for (int i = 0; i < 4; i++)  w[12+i] = n[31-8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hfe;
        for (int i = 0; i < 32; i++) begin
            k = (i <= 16) ? 8'h99 : 8'ha1;
            x = (i <= 16) ? (a ^ b) : (a ^ c);
            t = x + k + w[i];
            a = b ^ c;
            b = {c[3:0], 4'b0000};
            c = t;
        end
        return {8'h01 + a, 8'h89 + b, 8'hfe + c};
    endfunction

    function automatic logic model_meets(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [95:0] p, input logic [31:0] n,
                               input logic [23:0] h, input logic [7:0] t);
        logic [23:0] e;
        e = model_hash(p, n);
        chk({tag, "_hash"}, 32'(hash_calc), 32'(e));
        chk({tag, "_match"}, 32'(hash_match), 32'(e == h));
        chk({tag, "_meets"}, 32'(meets_target), 32'(model_meets(e, t)));
        chk({tag, "_valid"}, 32'(valido), 32'((e == h) && model_meets(e, t)));
    endtask

    task automatic drive(input logic [95:0] p, input logic [31:0] n, input logic [23:0] h, input logic [7:0] t);
        payload = p; nonce = n; hash_in = h; target = t;
    endtask

    // waits from the first negedge after accept until done; inj>=0 pulses a competing start at that cycle
    task automatic wait_done(input string tag, input int inj);
        int lat = 0;
        int busy_low = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            if (lat == inj) begin
                start = 1'b1;
                drive({$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'($urandom));
            end else begin
                start = 1'b0;
                drive({$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'($urandom));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_check(input string tag, input logic [95:0] p, input logic [31:0] n,
                             input logic [23:0] h, input logic [7:0] t, input int inj);
        @(negedge clk);
        drive(p, n, h, t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, inj);
        chk_results(tag, p, n, h, t);
        @(negedge clk);
        chk({tag, "_single_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [95:0] p0, p1, p2;
        logic [31:0] n0, n1;
        logic [23:0] h0, h1;
        logic [7:0]  t0;
        int nd;
        bit found;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hash", 32'(hash_calc), 32'd0);
        chk("rst_flags", 32'({hash_match, meets_target, valido}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        p0 = 96'h397d9f2f40ca9e6c6b1f3324;
        found = 1'b0;
        n0 = 32'd0;
        for (int i = 0; i < 400000 && !found; i++) begin
            if (model_meets(model_hash(p0, 32'(i)), 8'h0a)) begin
                n0 = 32'(i);
                found = 1'b1;
            end
        end
        chk("nonce_search", 32'(found), 32'd1);
        h0 = model_hash(p0, n0);

        run_check("roundtrip", p0, n0, h0, 8'h0a, -1);
        chk("roundtrip_valid_one", 32'(valido), 32'd1);
        run_check("mismatch", p0, n0, h0 ^ 24'h000001, 8'h0a, -1);
        chk("mismatch_hash_same", 32'(hash_calc), 32'(h0));
        run_check("target0", {$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'h00, -1);
        chk("target0_meets_zero", 32'(meets_target), 32'd0);

        for (int r = 0; r < 8; r++) begin
            p1 = {$urandom, $urandom, $urandom};
            n1 = $urandom;
            h1 = (r % 2 == 0) ? model_hash(p1, n1) : 24'($urandom);
            t0 = (r % 3 == 0) ? 8'hff : 8'($urandom);
            run_check("random", p1, n1, h1, t0, -1);
        end

        p1 = {$urandom, $urandom, $urandom};
        n1 = $urandom;
        run_check("busy_start", p1, n1, model_hash(p1, n1), 8'hc0, 5);

        @(negedge clk);
        drive(p0, n0, h0, 8'h0a);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hash", 32'(hash_calc), 32'd0);
        chk("abort_flags", 32'({done, hash_match, meets_target, valido}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_check("after_abort", p0, n0, h0, 8'h0a, -1);

        p1 = {$urandom, $urandom, $urandom};
        n1 = $urandom;
        p2 = {$urandom, $urandom, $urandom};
        @(negedge clk);
        drive(p1, n1, model_hash(p1, n1), 8'hff);
        start = 1'b1;
        @(negedge clk);
        nd = 0;
        while (done !== 1'b1 && nd < 60) begin
            @(negedge clk);
            nd++;
        end
        chk("held_first_latency", 32'(nd), 32'd33);
        chk_results("held_first", p1, n1, model_hash(p1, n1), 8'hff);
        drive(p2, n1, 24'h123456, 8'h80);
        @(negedge clk);
        start = 1'b0;
        chk("held_retrigger_busy", 32'(busy), 32'd1);
        chk("held_hold_hash", 32'(hash_calc), 32'(model_hash(p1, n1)));
        wait_done("held_second", -1);
        chk_results("held_second", p2, n1, 24'h123456, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
